// File: rtl/dnf_sweep_checker.sv
// ---------------------------------------------------------------------------
// dnf_sweep_checker
//
// Exhaustively sweeps every WIDTH-bit input vector into two external
// combinational implementations of the same boolean function. Typical pairs
// are the canonical and the minimised DNF forms. For each vector it samples
// both outputs and compares them. At the end it reports a pass/fail summary.
//
// Each vector is held for SETTLE cycles (APPLY) and then sampled for one
// cycle (SAMPLE). A vector therefore costs SETTLE+1 cycles. A full sweep runs
// from the start edge to the done pulse in 2^WIDTH*(SETTLE+1)+1 cycles.
//
// Parameters:
//   WIDTH   number of function inputs (sweep length 2^WIDTH)
//   SETTLE  hold cycles per vector before sampling (1..15)
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a sweep (honoured only in IDLE)
//   abort          cancel a running sweep (APPLY/SAMPLE only)
//   vec_out        vector applied to both implementations
//   f_a            reference implementation output
//   f_b            implementation under check output
//   busy           high while in APPLY or SAMPLE
//   done           one-cycle pulse when a sweep completes
//   pass           last completed sweep had zero mismatches
//   mismatch_cnt   number of vectors where f_a != f_b
//   ones_cnt       number of vectors where f_a = 1
//   first_bad      lowest mismatching vector
//   first_bad_vld  first_bad holds a valid value
// ---------------------------------------------------------------------------
module dnf_sweep_checker #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] vec_out,
    input  logic             f_a,
    input  logic             f_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   mismatch_cnt,
    output logic [WIDTH:0]   ones_cnt,
    output logic [WIDTH-1:0] first_bad,
    output logic             first_bad_vld
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t           state_q;
    logic [3:0]       settle_q;
    logic [WIDTH-1:0] vec_q;
    logic [WIDTH:0]   mismatchCnt_q;
    logic [WIDTH:0]   onesCnt_q;
    logic [WIDTH-1:0] firstBad_q;
    logic             firstBadVld_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             miss;
    logic [WIDTH:0]   mismatchCnt_d;
    logic [WIDTH:0]   onesCnt_d;

    // Next counter values for the SAMPLE cycle. They are only committed in
    // SAMPLE, so the outputs of the implementations are ignored while they
    // settle in APPLY. The final pass flag is taken from mismatchCnt_d so
    // that the last vector is included.
    always_comb begin
        miss          = (f_a != f_b);
        mismatchCnt_d = mismatchCnt_q;
        onesCnt_d     = onesCnt_q;
        if (miss) begin
            mismatchCnt_d = mismatchCnt_q + (WIDTH+1)'(1);
        end
        if (f_a) begin
            onesCnt_d = onesCnt_q + (WIDTH+1)'(1);
        end
    end

    // The sweep sequencer. All outputs are registered here, so busy and done
    // are set on the edge that enters the state in which they are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            settle_q      <= 4'd0;
            vec_q         <= '0;
            mismatchCnt_q <= '0;
            onesCnt_q     <= '0;
            firstBad_q    <= '0;
            firstBadVld_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // start beats abort here: abort has no meaning in IDLE.
                    if (start) begin
                        mismatchCnt_q <= '0;
                        onesCnt_q     <= '0;
                        firstBad_q    <= '0;
                        firstBadVld_q <= 1'b0;
                        pass_q        <= 1'b0;
                        vec_q         <= '0;
                        settle_q      <= 4'd1;
                        busy_q        <= 1'b1;
                        state_q       <= APPLY;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (settle_q == SETTLE_L) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end

                SAMPLE: begin
                    // abort wins, so the vector being sampled is dropped.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        mismatchCnt_q <= mismatchCnt_d;
                        onesCnt_q     <= onesCnt_d;
                        if (miss && !firstBadVld_q) begin
                            firstBad_q    <= vec_q;
                            firstBadVld_q <= 1'b1;
                        end
                        // The sweep ends on the all-ones vector. vec_q is
                        // left there instead of wrapping back to zero.
                        if (&vec_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (mismatchCnt_d == '0);
                            state_q <= FIN;
                        end else begin
                            vec_q    <= vec_q + WIDTH'(1);
                            settle_q <= 4'd1;
                            state_q  <= APPLY;
                        end
                    end
                end

                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_out       = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch_cnt  = mismatchCnt_q;
    assign ones_cnt      = onesCnt_q;
    assign first_bad     = firstBad_q;
    assign first_bad_vld = firstBadVld_q;

endmodule

// File: tb/tb_dnf_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_dnf_sweep_checker
//
// Directed testbench for dnf_sweep_checker.
//
// dut1 uses WIDTH=5 and SETTLE=1. It covers reset, clean sweeps, injected
// faults, abort, spurious start and reset in the middle of a sweep.
//
// dut3 uses SETTLE=3. It checks that settling glitches are filtered out.
//
// The function under test is f = v[0]^v[2]^v[4]. It has 16 true minterms,
// among them 1, 3, 6 and 31.
// ---------------------------------------------------------------------------
module tb_dnf_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, abort1, start3, abort3;
    logic [4:0] vec1, vec3;
    logic       fA1, fB1, fA3, fB3;
    logic       busy1, done1, pass1, fbv1;
    logic       busy3, done3, pass3, fbv3;
    logic [5:0] mm1, ones1, mm3, ones3;
    logic [4:0] fb1, fb3;
    int         faultMode;
    logic       glitch3;
    int         checks;
    int         errors;

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Reference function. In fault mode the checked copy of dut1 flips
    // its output on vectors 9 and 30.
    assign fA1 = vec1[0] ^ vec1[2] ^ vec1[4];
    assign fB1 = fA1 ^ ((faultMode != 0) && (vec1 == 5'd9 || vec1 == 5'd30));
    assign fA3 = vec3[0] ^ vec3[2] ^ vec3[4];
    assign fB3 = fA3 ^ glitch3;

    dnf_sweep_checker #(.WIDTH(5), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .vec_out(vec1), .f_a(fA1), .f_b(fB1), .busy(busy1), .done(done1),
        .pass(pass1), .mismatch_cnt(mm1), .ones_cnt(ones1),
        .first_bad(fb1), .first_bad_vld(fbv1)
    );

    dnf_sweep_checker #(.WIDTH(5), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .vec_out(vec3), .f_a(fA3), .f_b(fB3), .busy(busy3), .done(done3),
        .pass(pass3), .mismatch_cnt(mm3), .ones_cnt(ones3),
        .first_bad(fb3), .first_bad_vld(fbv3)
    );

    // Runs one complete dut1 sweep, starting from #1 after an edge.
    // Cycle k is the interval that follows the (k-1)th edge after the start
    // edge. busy should be high in cycles 1..64, and done should pulse in
    // cycle 65.
    task automatic runSweep1(input logic withAbort, output int busyCycles,
                             output int doneCycle, output int doneCount,
                             output int stepErrors);
        busyCycles = 0; doneCycle = -1; doneCount = 0; stepErrors = 0;
        start1 = 1'b1;
        abort1 = withAbort;
        @(posedge clk); #1;
        start1 = 1'b0;
        abort1 = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (busy1 === 1'b1) busyCycles++;
            if (done1 === 1'b1) begin
                doneCount++;
                doneCycle = k;
            end
            if (k <= 64 && vec1 !== 5'((k - 1) / 2)) stepErrors++;
            @(posedge clk); #1;
        end
    endtask

    // Asserts reset between clock edges and checks that every output
    // clears without waiting for an edge. After reset is released, the
    // FSM must stay idle.
    task automatic test_reset();
        rst_n = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        faultMode = 0; glitch3 = 1'b0;
        #12;
        rst_n = 1'b0;
        #1;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %b expected 0", pass1); end
        checks++; if (vec1 !== 5'd0) begin errors++; $display("[TB] FAIL reset_vec got %0d expected 0", vec1); end
        checks++; if (mm1 !== 6'd0 || ones1 !== 6'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d expected 0/0", mm1, ones1); end
        checks++; if (fb1 !== 5'd0 || fbv1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_bad got %0d/%b expected 0/0", fb1, fbv1); end
        checks++; if (busy3 !== 1'b0 || vec3 !== 5'd0) begin errors++; $display("[TB] FAIL reset_dut3 got busy %b vec %0d expected 0/0", busy3, vec3); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b0 || vec1 !== 5'd0 || done1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle got busy %b vec %0d done %b expected 0/0/0", busy1, vec1, done1); end
    endtask

    // A sweep in which both implementations agree on every vector.
    task automatic test_clean_sweep();
        int bc, dc, dn, se;
        faultMode = 0;
        runSweep1(1'b0, bc, dc, dn, se);
        checks++; if (bc != 64) begin errors++; $display("[TB] FAIL clean_busy_cycles got %0d expected 64", bc); end
        checks++; if (dn != 1 || dc != 65) begin errors++; $display("[TB] FAIL clean_done got count %0d cycle %0d expected 1/65", dn, dc); end
        checks++; if (se != 0) begin errors++; $display("[TB] FAIL clean_vec_steps got %0d bad cycles expected 0", se); end
        checks++; if (pass1 !== 1'b1) begin errors++; $display("[TB] FAIL clean_pass got %b expected 1", pass1); end
        checks++; if (mm1 !== 6'd0) begin errors++; $display("[TB] FAIL clean_mismatch got %0d expected 0", mm1); end
        checks++; if (ones1 !== 6'd16) begin errors++; $display("[TB] FAIL clean_ones got %0d expected 16", ones1); end
        checks++; if (fbv1 !== 1'b0) begin errors++; $display("[TB] FAIL clean_first_bad_vld got %b expected 0", fbv1); end
        checks++; if (vec1 !== 5'd31) begin errors++; $display("[TB] FAIL clean_vec_no_wrap got %0d expected 31", vec1); end
    endtask

    // Vectors 9 and 30 are corrupted in the implementation under check.
    task automatic test_fault_inject();
        int bc, dc, dn, se;
        faultMode = 1;
        runSweep1(1'b0, bc, dc, dn, se);
        checks++; if (dn != 1 || dc != 65) begin errors++; $display("[TB] FAIL fault_done got count %0d cycle %0d expected 1/65", dn, dc); end
        checks++; if (mm1 !== 6'd2) begin errors++; $display("[TB] FAIL fault_mismatch got %0d expected 2", mm1); end
        checks++; if (fb1 !== 5'd9 || fbv1 !== 1'b1) begin errors++; $display("[TB] FAIL fault_first_bad got %0d/%b expected 9/1", fb1, fbv1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL fault_pass got %b expected 0", pass1); end
        checks++; if (ones1 !== 6'd16) begin errors++; $display("[TB] FAIL fault_ones got %0d expected 16", ones1); end
        faultMode = 0;
    endtask

    // Start is pulsed again while vector 5 is applied and must be ignored.
    // Abort is then raised in the SAMPLE cycle of vector 12 (cycle 26).
    // Vectors 0..11 are counted: one mismatch (vector 9) and six ones.
    task automatic test_abort();
        int doneSeen;
        doneSeen = 0;
        faultMode = 1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            if (done1 === 1'b1) doneSeen++;
            if (k == 11) begin
                checks++; if (vec1 !== 5'd5) begin errors++; $display("[TB] FAIL abort_vec_at_11 got %0d expected 5", vec1); end
                start1 = 1'b1;
            end
            if (k == 12) begin
                start1 = 1'b0;
                checks++; if (vec1 !== 5'd5 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL spurious_start got vec %0d busy %b expected 5/1", vec1, busy1); end
            end
            if (k == 26) begin
                checks++; if (vec1 !== 5'd12) begin errors++; $display("[TB] FAIL abort_vec_at_26 got %0d expected 12", vec1); end
                abort1 = 1'b1;
            end
            @(posedge clk); #1;
        end
        abort1 = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b expected 0", busy1); end
        checks++; if (pass1 !== 1'b0) begin errors++; $display("[TB] FAIL abort_pass got %b expected 0", pass1); end
        checks++; if (vec1 !== 5'd12) begin errors++; $display("[TB] FAIL abort_vec_hold got %0d expected 12", vec1); end
        checks++; if (mm1 !== 6'd1 || ones1 !== 6'd6) begin errors++; $display("[TB] FAIL abort_counts got %0d/%0d expected 1/6", mm1, ones1); end
        checks++; if (fb1 !== 5'd9 || fbv1 !== 1'b1) begin errors++; $display("[TB] FAIL abort_first_bad got %0d/%b expected 9/1", fb1, fbv1); end
        for (int k = 0; k < 4; k++) begin
            if (done1 === 1'b1) doneSeen++;
            @(posedge clk); #1;
        end
        checks++; if (doneSeen != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses expected 0", doneSeen); end
        checks++; if (busy1 !== 1'b0 || vec1 !== 5'd12) begin errors++; $display("[TB] FAIL abort_stays_idle got busy %b vec %0d expected 0/12", busy1, vec1); end
        faultMode = 0;
    endtask

    // Reset arrives in the middle of a sweep and clears everything at once.
    // A fresh sweep then starts with start and abort raised together, and
    // start must win.
    task automatic test_reset_mid_sweep();
        int bc, dc, dn, se, budget;
        faultMode = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        budget = 0;
        while (vec1 !== 5'd20 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++; if (budget >= 100) begin errors++; $display("[TB] FAIL midreset_reach_20 got vec %0d expected 20", vec1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got busy %b done %b pass %b expected 0/0/0", busy1, done1, pass1); end
        checks++; if (vec1 !== 5'd0 || ones1 !== 6'd0 || mm1 !== 6'd0) begin errors++; $display("[TB] FAIL midreset_values got vec %0d ones %0d mm %0d expected 0/0/0", vec1, ones1, mm1); end
        checks++; if (fb1 !== 5'd0 || fbv1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_first_bad got %0d/%b expected 0/0", fb1, fbv1); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        runSweep1(1'b1, bc, dc, dn, se);
        checks++; if (bc != 64 || dn != 1 || dc != 65 || se != 0) begin errors++; $display("[TB] FAIL midreset_resweep_timing got busy %0d done %0d@%0d steps %0d expected 64 1@65 0", bc, dn, dc, se); end
        checks++; if (pass1 !== 1'b1 || mm1 !== 6'd0 || ones1 !== 6'd16 || fbv1 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_resweep_results got pass %b mm %0d ones %0d vld %b expected 1 0 16 0", pass1, mm1, ones1, fbv1); end
    endtask

    // dut3 (SETTLE=3). f_b disagrees with f_a in the first APPLY cycle of
    // every vector. Those glitches fall inside the settle window, so they
    // must not be counted.
    task automatic test_settle();
        int bc, dc, dn, se;
        bc = 0; dc = -1; dn = 0; se = 0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            glitch3 = (k <= 128) && (((k - 1) % 4) == 0);
            if (busy3 === 1'b1) bc++;
            if (done3 === 1'b1) begin
                dn++;
                dc = k;
            end
            if (k <= 128 && vec3 !== 5'((k - 1) / 4)) se++;
            @(posedge clk); #1;
        end
        glitch3 = 1'b0;
        checks++; if (bc != 128) begin errors++; $display("[TB] FAIL settle_busy_cycles got %0d expected 128", bc); end
        checks++; if (dn != 1 || dc != 129) begin errors++; $display("[TB] FAIL settle_done got count %0d cycle %0d expected 1/129", dn, dc); end
        checks++; if (se != 0) begin errors++; $display("[TB] FAIL settle_vec_steps got %0d bad cycles expected 0", se); end
        checks++; if (mm3 !== 6'd0 || pass3 !== 1'b1) begin errors++; $display("[TB] FAIL settle_result got mm %0d pass %b expected 0/1", mm3, pass3); end
        checks++; if (ones3 !== 6'd16) begin errors++; $display("[TB] FAIL settle_ones got %0d expected 16", ones3); end
    endtask

    // Runs the scenarios in order and prints the summary line.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clean_sweep();
        test_fault_inject();
        test_abort();
        test_reset_mid_sweep();
        test_settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnf_sweep_checker.md
Name: dnf_sweep_checker

Overview:
- Sequencer that drives all 2^WIDTH input vectors into two combinational implementations of the same boolean function, for example the canonical and the minimised DNF forms.
- Samples both outputs for each vector, compares them, and reports a pass/fail summary.
- Sits between a test-harness top and the two function blocks.
- The function blocks are instantiated externally: this block drives `vec_out` into both and receives `f_a` and `f_b` back.

Parameters:
- WIDTH, 5, number of function inputs; sweep length is 2^WIDTH vectors.
- SETTLE, 1, cycles each vector is held before sampling; legal range is 1 to 15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a running sweep.
- vec_out  output  WIDTH  vector currently applied to both implementations.
- f_a  input  1  output of the reference implementation.
- f_b  input  1  output of the implementation under check.
- busy  output  1  high while sweeping (APPLY or SAMPLE).
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- mismatch_cnt  output  WIDTH+1  number of vectors where f_a != f_b.
- ones_cnt  output  WIDTH+1  number of vectors where f_a = 1.
- first_bad  output  WIDTH  lowest mismatching vector.
- first_bad_vld  output  1  first_bad holds a valid value.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of current state:
  - state = IDLE;
  - vec_out, mismatch_cnt, ones_cnt and first_bad = 0;
  - busy, done, pass and first_bad_vld = 0.
- FSM states: IDLE, APPLY, SAMPLE, FIN.
- IDLE:
  - start=1 at a clock edge: clear all result outputs, set vec_out=0 and the settle counter to 1, go to APPLY.
  - busy rises in the first APPLY cycle.
  - start=0: remain in IDLE; results hold.
- APPLY:
  - vec_out is held constant.
  - When the settle counter equals SETTLE, go to SAMPLE; otherwise increment the counter.
  - f_a and f_b are ignored in APPLY, so glitches during settling are not counted.
- SAMPLE (one cycle). At the closing edge:
  - if f_a != f_b: mismatch_cnt += 1;
  - if f_a = 1: ones_cnt += 1;
  - if f_a != f_b and first_bad_vld=0: first_bad = vec_out and first_bad_vld = 1.
  - Then, if vec_out is all ones, go to FIN.
  - Otherwise vec_out += 1, the settle counter is reset to 1, and the FSM goes to APPLY.
  - vec_out never wraps during a sweep.
- FIN (one cycle):
  - done=1, busy=0, pass = (mismatch_cnt == 0); next state is IDLE.
  - pass and the result counters hold until the next accepted start or reset.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - From the start edge to the done pulse is 2^WIDTH*(SETTLE+1)+1 cycles.
  - For WIDTH=5, SETTLE=1: 65 cycles.
- start while busy or in FIN: ignored, with no restart and no counter disturbance.
- abort:
  - In APPLY or SAMPLE: go to IDLE at the next edge.
  - No done pulse; pass=0.
  - Counters freeze at their partial values; vec_out holds.
  - abort has priority over the SAMPLE update in the same cycle, so the vector is not counted.
  - In IDLE or FIN: no effect.
- start and abort high together in IDLE: start wins and the sweep begins.
- Counter widths: WIDTH+1 bits, so the full count 2^WIDTH (32 for WIDTH=5) is representable without overflow.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset check:
   - Assert rst_n=0 mid-cycle with no clock.
   - Required: all outputs go to 0 immediately; after release the FSM stays in IDLE with busy=0.
2. Clean sweep (WIDTH=5, SETTLE=1):
   - Stimulus: f_b tied to f_a; f_a is a function with 16 true minterms, including vectors 1, 3, 6 and 31; start pulsed one cycle.
   - Required: busy high 64 cycles; vec_out steps 0..31, changing every 2 cycles; done pulses once at cycle 65; pass=1, mismatch_cnt=0, ones_cnt=16, first_bad_vld=0.
3. Injected faults:
   - Stimulus: f_b = f_a XOR (vec_out==9 OR vec_out==30).
   - Required: mismatch_cnt=2, first_bad=9, first_bad_vld=1, pass=0, ones_cnt=16.
4. Abort and spurious start:
   - Pulse start again at vec_out=5: required no effect.
   - Assert abort in the SAMPLE cycle of vec_out=12: required IDLE next cycle, no done, pass=0, vec_out holds 12, and vector 12 is not counted.
5. Reset mid-sweep:
   - Drop rst_n at vec_out=20: required immediate clear of all outputs.
   - Release rst_n and start: required a full clean sweep with results identical to scenario 2.
6. Settle filtering (SETTLE=3):
   - Stimulus: f_b forced opposite to f_a during the first APPLY cycle of every vector, equal otherwise.
   - Required: vec_out changes every 4 cycles; done at cycle 129; mismatch_cnt=0, pass=1.
